// File: rtl/mem_axi_lite_master_pkg.sv
// Shared types and constants for the MEM-stage AXI4-Lite data master.
package mem_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/mem_axi_lite_master_if.sv
// AXI4-Lite bus bundle between the data master and its slave.
interface mem_axi_lite_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m_awaddr;
    logic [2:0]        m_awprot;
    logic              m_awvalid;
    logic              m_awready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [ADDR_W-1:0] m_araddr;
    logic [2:0]        m_arprot;
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arprot, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awprot, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arprot, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for stores (strobes, replicated data) and load extraction with sign/zero extend.
module mem_lsu_align
    import mem_axi_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  strobe,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_en;

    // Halves only look at offset[1]; misaligned accesses are truncated, never split.
    assign byte_lane = bus_rdata[{offset, 3'b000} +: 8];
    assign half_lane = bus_rdata[{offset[1], 4'b0000} +: 16];
    assign sign_en   = ~funct3[2];

    always_comb begin
        strobe    = 4'hF;
        bus_wdata = store_data;
        load_data = bus_rdata;
        case (funct3[1:0])
            F3_B[1:0]: begin
                strobe    = 4'b0001 << offset;
                bus_wdata = {4{store_data[7:0]}};
                load_data = {{24{byte_lane[7] & sign_en}}, byte_lane};
            end
            F3_H[1:0]: begin
                strobe    = 4'b0011 << {offset[1], 1'b0};
                bus_wdata = {2{store_data[15:0]}};
                load_data = {{16{half_lane[15] & sign_en}}, half_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_axi_lite_master.sv
// MEM-stage AXI4-Lite data master: one load/store at a time, stalling the pipeline until done.
// Optional macro MEM_AXI_RESP_ERR_EN adds sticky bus_err_o / bus_err_addr_o reporting.
module mem_axi_lite_master
    import mem_axi_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter logic [2:0] AXI_PROT = AXI_PROT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              axi_stall,
    mem_axi_lite_master_if.master bus
`ifdef MEM_AXI_RESP_ERR_EN
   ,output logic              bus_err_o,
    output logic [ADDR_W-1:0] bus_err_addr_o
`endif
);

    state_t            state, nxt_state;
    logic [ADDR_W-1:0] req_addr, nxt_addr;
    logic [31:0]       req_wdata, nxt_wdata;
    logic [2:0]        req_funct3, nxt_funct3;
    logic              awvalid, nxt_awvalid;
    logic              wvalid, nxt_wvalid;
    logic              bready, nxt_bready;
    logic              arvalid, nxt_arvalid;
    logic              rready, nxt_rready;
    logic [31:0]       rdata_q, nxt_rdata;
    logic [3:0]        strobe;
    logic [31:0]       bus_wdata;
    logic [31:0]       load_data;

    mem_lsu_align u_align (
        .funct3     (req_funct3),
        .offset     (req_addr[1:0]),
        .store_data (req_wdata),
        .bus_rdata  (bus.m_rdata),
        .strobe     (strobe),
        .bus_wdata  (bus_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_funct3 <= '0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= nxt_state;
            req_addr   <= nxt_addr;
            req_wdata  <= nxt_wdata;
            req_funct3 <= nxt_funct3;
            awvalid    <= nxt_awvalid;
            wvalid     <= nxt_wvalid;
            bready     <= nxt_bready;
            arvalid    <= nxt_arvalid;
            rready     <= nxt_rready;
            rdata_q    <= nxt_rdata;
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_addr    = req_addr;
        nxt_wdata   = req_wdata;
        nxt_funct3  = req_funct3;
        nxt_awvalid = awvalid;
        nxt_wvalid  = wvalid;
        nxt_bready  = bready;
        nxt_arvalid = arvalid;
        nxt_rready  = rready;
        nxt_rdata   = rdata_q;
        axi_stall   = 1'b1;
        case (state)
            S_IDLE: begin
                axi_stall = mem_read_i | mem_write_i;
                if (mem_write_i || mem_read_i) begin
                    nxt_addr   = addr_i;
                    nxt_wdata  = wdata_i;
                    nxt_funct3 = funct3_i;
                end
                if (mem_write_i) begin
                    nxt_awvalid = 1'b1;
                    nxt_wvalid  = 1'b1;
                    nxt_state   = S_WR;
                end else if (mem_read_i) begin
                    nxt_arvalid = 1'b1;
                    nxt_state   = S_RD_ADDR;
                end
            end
            S_WR: begin
                // AW and W retire independently; move on once neither is pending.
                if (awvalid && bus.m_awready) nxt_awvalid = 1'b0;
                if (wvalid && bus.m_wready)   nxt_wvalid  = 1'b0;
                if (!nxt_awvalid && !nxt_wvalid) begin
                    nxt_bready = 1'b1;
                    nxt_state  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bus.m_bvalid) begin
                    nxt_bready = 1'b0;
                    nxt_state  = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (bus.m_arready) begin
                    nxt_arvalid = 1'b0;
                    nxt_rready  = 1'b1;
                    nxt_state   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (bus.m_rvalid) begin
                    nxt_rready = 1'b0;
                    nxt_rdata  = load_data;
                    nxt_state  = S_DONE;
                end
            end
            S_DONE: begin
                // The pipeline still presents the finished request this cycle, so do not re-issue it.
                axi_stall = 1'b0;
                nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    assign rdata_o       = rdata_q;
    assign bus.m_awaddr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign bus.m_araddr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign bus.m_awprot  = AXI_PROT;
    assign bus.m_arprot  = AXI_PROT;
    assign bus.m_awvalid = awvalid;
    assign bus.m_wvalid  = wvalid;
    assign bus.m_wdata   = bus_wdata;
    assign bus.m_wstrb   = strobe;
    assign bus.m_bready  = bready;
    assign bus.m_arvalid = arvalid;
    assign bus.m_rready  = rready;

`ifdef MEM_AXI_RESP_ERR_EN
    logic resp_err;

    always_comb begin
        resp_err = 1'b0;
        if (state == S_WR_RESP && bus.m_bvalid && bus.m_bresp != AXI_RESP_OKAY) resp_err = 1'b1;
        if (state == S_RD_DATA && bus.m_rvalid && bus.m_rresp != AXI_RESP_OKAY) resp_err = 1'b1;
    end

    // Sticky: only the first failing address is kept until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_o      <= 1'b0;
            bus_err_addr_o <= '0;
        end else if (resp_err && !bus_err_o) begin
            bus_err_o      <= 1'b1;
            bus_err_addr_o <= req_addr;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{bus.m_bresp, bus.m_rresp};
`endif

endmodule

// File: tb/tb_mem_axi_lite_master.sv
// Bench for mem_axi_lite_master: directed cases plus random loads/stores against a byte-addressed memory model.
module tb_mem_axi_lite_master;
    import mem_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        axi_stall;
`ifdef MEM_AXI_RESP_ERR_EN
    logic        bus_err;
    logic [31:0] bus_err_addr;
`endif

    mem_axi_lite_master_if #(.ADDR_W(32)) bus ();

    mem_axi_lite_master #(.ADDR_W(32), .AXI_PROT(3'b000)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .axi_stall   (axi_stall),
        .bus         (bus)
`ifdef MEM_AXI_RESP_ERR_EN
       ,.bus_err_o      (bus_err),
        .bus_err_addr_o (bus_err_addr)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural slave with programmable latencies ----------------
    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int         aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit         aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_s, w_data_s, r_data_s, a_use, d_use;
    logic [3:0]  w_strb_s, s_use;
    logic [31:0] smem [0:255];
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign bus.m_awready = bus.m_awvalid && (aw_wait == aw_delay);
    assign bus.m_wready  = bus.m_wvalid && (w_wait == w_delay);
    assign bus.m_bvalid  = b_pend && (b_wait == b_delay);
    assign bus.m_arready = bus.m_arvalid && (ar_wait == ar_delay);
    assign bus.m_rvalid  = r_pend && (r_wait == r_delay);
    assign bus.m_bresp   = bresp_cfg;
    assign bus.m_rresp   = rresp_cfg;
    assign bus.m_rdata   = r_data_s;
    assign aw_hs = bus.m_awvalid && bus.m_awready;
    assign w_hs  = bus.m_wvalid && bus.m_wready;
    assign b_hs  = bus.m_bvalid && bus.m_bready;
    assign ar_hs = bus.m_arvalid && bus.m_arready;
    assign r_hs  = bus.m_rvalid && bus.m_rready;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            if (aw_hs) begin aw_got <= 1; aw_addr_s <= bus.m_awaddr; aw_wait <= 0; end
            else if (bus.m_awvalid && aw_wait != aw_delay) aw_wait <= aw_wait + 1;
            if (w_hs) begin w_got <= 1; w_data_s <= bus.m_wdata; w_strb_s <= bus.m_wstrb; w_wait <= 0; end
            else if (bus.m_wvalid && w_wait != w_delay) w_wait <= w_wait + 1;
            if (ar_hs) begin r_pend <= 1; r_wait <= 0; r_data_s <= smem[bus.m_araddr[9:2]]; ar_wait <= 0; end
            else if (bus.m_arvalid && ar_wait != ar_delay) ar_wait <= ar_wait + 1;
            if (r_hs) r_pend <= 0;
            else if (r_pend && r_wait != r_delay) r_wait <= r_wait + 1;
            if (b_hs) b_pend <= 0;
            else if (b_pend && b_wait != b_delay) b_wait <= b_wait + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                a_use = aw_hs ? bus.m_awaddr : aw_addr_s;
                d_use = w_hs ? bus.m_wdata : w_data_s;
                s_use = w_hs ? bus.m_wstrb : w_strb_s;
                for (int k = 0; k < 4; k++)
                    if (s_use[k]) smem[a_use[9:2]][8*k +: 8] <= d_use[8*k +: 8];
                b_pend <= 1; b_wait <= 0; aw_got <= 0; w_got <= 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, awv_cyc = 0, wv_cyc = 0;
    logic [31:0] mon_awaddr, mon_wdata, mon_araddr;
    logic [3:0]  mon_wstrb;

    always @(posedge clk) begin
        if (aw_hs) begin aw_cnt <= aw_cnt + 1; mon_awaddr <= bus.m_awaddr; end
        if (w_hs) begin w_cnt <= w_cnt + 1; mon_wdata <= bus.m_wdata; mon_wstrb <= bus.m_wstrb; end
        if (ar_hs) begin ar_cnt <= ar_cnt + 1; mon_araddr <= bus.m_araddr; end
        if (bus.m_awvalid) awv_cyc <= awv_cyc + 1;
        if (bus.m_wvalid) wv_cyc <= wv_cyc + 1;
    end

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0] ref_bytes [int];

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             output logic [3:0] exp_strb, output logic [31:0] exp_wdata);
        int sz, base;
        sz = size_of(f3);
        base = int'(a) - (int'(a) % sz);
        exp_strb = '0;
        for (int i = 0; i < sz; i++) begin
            ref_bytes[base + i] = wd[8*i +: 8];
            exp_strb[(base % 4) + i] = 1'b1;
        end
        for (int lane = 0; lane < 4; lane++) exp_wdata[8*lane +: 8] = wd[8*(lane % sz) +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz, base;
        longint v;
        sz = size_of(f3);
        base = int'(a) - (int'(a) % sz);
        v = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_bytes[base + i]) << (8*i);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= (longint'(1) << (8*sz));
        return v[31:0];
    endfunction

    // ---------------- checking helpers ----------------
    int n_pass = 0, n_total = 0, n_fail = 0;
    int stall_n;
    logic [4:0] done_vld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] bus_ctl();
        return {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready};
    endfunction

    // Presents a request, holds it while stalled (including the DONE cycle), and counts stalled cycles.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, output int stalls);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        stalls = 0;
        done_vld = '1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!axi_stall) begin
                done_vld = bus_ctl();
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
    endtask

    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rdata, held;
    int a0, w0, ar0, awv0, wv0;
    logic [31:0] ra, rd_v;
    logic [2:0]  rf3;
    bit          rwr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {27'd0, bus_ctl()}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_stall", {31'd0, axi_stall}, 32'd0);
`ifdef MEM_AXI_RESP_ERR_EN
        check("reset_err", {31'd0, bus_err}, 32'd0);
`endif
        rst = 0;
        @(posedge clk); #1;

        // SW with an always-ready slave
        a0 = aw_cnt; w0 = w_cnt;
        ref_store(F3_W, 32'h104, 32'hDEADBEEF, e_strb, e_wdata);
        do_access(0, 1, F3_W, 32'h104, 32'hDEADBEEF, stall_n);
        check("sw_stall", stall_n, 3);
        check("sw_awaddr", mon_awaddr, 32'h104);
        check("sw_wstrb", {28'd0, mon_wstrb}, 32'hF);
        check("sw_wdata", mon_wdata, 32'hDEADBEEF);
        check("sw_aw_count", aw_cnt - a0, 1);
        check("sw_w_count", w_cnt - w0, 1);

        // SB with AW accepted two cycles late
        aw_delay = 2;
        awv0 = awv_cyc; wv0 = wv_cyc;
        ref_store(F3_B, 32'h103, 32'h000000A5, e_strb, e_wdata);
        do_access(0, 1, F3_B, 32'h103, 32'h000000A5, stall_n);
        check("sb_wstrb", {28'd0, mon_wstrb}, 32'b1000);
        check("sb_wdata", mon_wdata, 32'hA5A5A5A5);
        check("sb_awaddr", mon_awaddr, 32'h100);
        check("sb_awvalid_cycles", awv_cyc - awv0, 3);
        check("sb_wvalid_cycles", wv_cyc - wv0, 1);
        check("sb_stall", stall_n, 5);
        aw_delay = 0;

        // Loads from word 0x80FF7F01
        ref_store(F3_W, 32'h108, 32'h80FF7F01, e_strb, e_wdata);
        do_access(0, 1, F3_W, 32'h108, 32'h80FF7F01, stall_n);
        do_access(1, 0, F3_B, 32'h10B, 32'h0, stall_n);
        check("lb_off3", rdata, 32'hFFFFFF80);
        check("lb_stall", stall_n, 3);
        do_access(1, 0, F3_BU, 32'h10B, 32'h0, stall_n);
        check("lbu_off3", rdata, 32'h00000080);
        do_access(1, 0, F3_H, 32'h10A, 32'h0, stall_n);
        check("lh_off2", rdata, 32'hFFFF80FF);
        do_access(1, 0, F3_HU, 32'h10B, 32'h0, stall_n);
        check("lhu_misaligned", rdata, 32'h000080FF);
        ar_delay = 3; r_delay = 2;
        do_access(1, 0, F3_W, 32'h10A, 32'h0, stall_n);
        check("lw_delayed", rdata, 32'h80FF7F01);
        check("lw_araddr", mon_araddr, 32'h108);
        check("lw_stall", stall_n, 8);
        ar_delay = 0; r_delay = 0;

        // Back-to-back LW then SW, each held through its DONE cycle
        ar0 = ar_cnt; a0 = aw_cnt;
        do_access(1, 0, F3_W, 32'h108, 32'h0, stall_n);
        check("b2b_done_idle", {27'd0, done_vld}, 32'd0);
        held = rdata;
        ref_store(F3_W, 32'h10C, 32'h13572468, e_strb, e_wdata);
        do_access(0, 1, F3_W, 32'h10C, 32'h13572468, stall_n);
        check("b2b_ar_once", ar_cnt - ar0, 1);
        check("b2b_aw_once", aw_cnt - a0, 1);
        check("b2b_rdata_held", rdata, 32'h80FF7F01);
        check("b2b_rdata_held_same", rdata, held);

        // Read and write together: the write goes out, the read does not
        ar0 = ar_cnt; a0 = aw_cnt;
        ref_store(F3_H, 32'h112, 32'h0000BEEF, e_strb, e_wdata);
        do_access(1, 1, F3_H, 32'h112, 32'h0000BEEF, stall_n);
        check("both_aw", aw_cnt - a0, 1);
        check("both_no_ar", ar_cnt - ar0, 0);
        check("both_wstrb", {28'd0, mon_wstrb}, {28'd0, e_strb});

        // Initialise 0x100..0x13F, then random traffic
        for (int k = 0; k < 16; k++) begin
            rd_v = $urandom;
            ref_store(F3_W, 32'h100 + 4*k, rd_v, e_strb, e_wdata);
            do_access(0, 1, F3_W, 32'h100 + 4*k, rd_v, stall_n);
        end
        for (int n = 0; n < 40; n++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            rwr = 1'($urandom_range(0, 1));
            ra = 32'h100 + $urandom_range(0, 63);
            rd_v = $urandom;
            if (rwr) begin
                rf3 = 3'($urandom_range(0, 2));
                ref_store(rf3, ra, rd_v, e_strb, e_wdata);
                do_access(0, 1, rf3, ra, rd_v, stall_n);
                check("rnd_wstrb", {28'd0, mon_wstrb}, {28'd0, e_strb});
                check("rnd_wdata", mon_wdata, e_wdata);
                check("rnd_awaddr", mon_awaddr, ra & 32'hFFFFFFFC);
                check("rnd_wr_stall", stall_n, 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay);
            end else begin
                rf3 = 3'($urandom_range(0, 4));
                if (rf3 > 3'd2) rf3 = rf3 + 3'd1;
                e_rdata = ref_load(rf3, ra);
                do_access(1, 0, rf3, ra, 32'h0, stall_n);
                check("rnd_rdata", rdata, e_rdata);
                check("rnd_araddr", mon_araddr, ra & 32'hFFFFFFFC);
                check("rnd_rd_stall", stall_n, 3 + ar_delay + r_delay);
            end
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
`ifdef MEM_AXI_RESP_ERR_EN
        check("no_err_after_okay", {31'd0, bus_err}, 32'd0);
`endif

        // Reset while waiting in the read-data phase
        r_delay = 5;
        mem_read = 1; funct3 = F3_W; addr = 32'h108;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_rready) break;
        end
        check("rst_mid_reached_rdata", {31'd0, bus.m_rready}, 32'd1);
        check("rst_mid_rdata_before", (rdata != 32'd0) ? 32'd1 : 32'd0, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        check("rst_mid_ctl", {27'd0, bus_ctl()}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_stall_follows", {31'd0, axi_stall}, 32'd1);
        rst = 0; mem_read = 0;
        #1;
        check("rst_mid_stall_low", {31'd0, axi_stall}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_quiet", {27'd0, bus_ctl()}, 32'd0);
        r_delay = 0;

`ifdef MEM_AXI_RESP_ERR_EN
        rresp_cfg = AXI_RESP_SLVERR;
        do_access(1, 0, F3_W, 32'h2000, 32'h0, stall_n);
        check("err_set", {31'd0, bus_err}, 32'd1);
        check("err_addr", bus_err_addr, 32'h2000);
        do_access(1, 0, F3_W, 32'h3000, 32'h0, stall_n);
        check("err_first_kept", bus_err_addr, 32'h2000);
        rresp_cfg = AXI_RESP_OKAY;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("err_cleared", {31'd0, bus_err}, 32'd0);
        check("err_addr_cleared", bus_err_addr, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
